// File: rtl/mul_div_unit.sv
// Iterative 32-bit unsigned multiply/divide unit (MUL, MULHU, DIVU, REMU).
// Processes one bit per cycle. Divide-by-zero bypasses the iterative phase.
module mul_div_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  input  logic [REG_ADDR_WIDTH-1:0] dest_register,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [REG_ADDR_WIDTH-1:0] result_register
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state_q;
  logic [CW-1:0]             cnt_q;
  logic [1:0]                op_q;
  logic [W-1:0]              opnd_q;
  logic [2*W-1:0]            prod_q;
  logic [W-1:0]              rem_q;
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic                      done_q;
  logic [W-1:0]              result_q;
  logic [REG_ADDR_WIDTH-1:0] rreg_q;

  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_d;
  logic [W:0]     trial;
  logic           qbit;
  logic [W-1:0]   rem_d;
  logic [W-1:0]   quot_d;
  logic [W-1:0]   res_d;

  // Multiply keeps the multiplier in prod_q[W-1:0]; divide keeps the
  // dividend/quotient there and the partial remainder in rem_q.
  always_comb begin
    mul_sum = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    mul_d   = {mul_sum, prod_q[W-1:1]};
    trial   = {rem_q, prod_q[W-1]};
    qbit    = trial[W] | (trial[W-1:0] >= opnd_q);
    rem_d   = qbit ? (trial[W-1:0] - opnd_q) : trial[W-1:0];
    quot_d  = {prod_q[W-2:0], qbit};
    case (op_q)
      2'b00:   res_d = mul_d[W-1:0];
      2'b01:   res_d = mul_d[2*W-1:W];
      2'b10:   res_d = quot_d;
      default: res_d = rem_d;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      dest_q   <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      rreg_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          cnt_q  <= '0;
          if (start) begin
            op_q   <= op;
            dest_q <= dest_register;
            rem_q  <= '0;
            if (op[1] && operand_b == '0) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= op[0] ? operand_a : '1;
              rreg_q   <= dest_register;
            end else if (op[1]) begin
              state_q <= RUN;
              opnd_q  <= operand_b;
              prod_q  <= {{W{1'b0}}, operand_a};
            end else begin
              state_q <= RUN;
              opnd_q  <= operand_a;
              prod_q  <= {{W{1'b0}}, operand_b};
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + CW'(1);
          if (op_q[1]) begin
            prod_q <= {{W{1'b0}}, quot_d};
            rem_q  <= rem_d;
          end else begin
            prod_q <= mul_d;
          end
          if (cnt_q == CW'(W - 1)) begin
            state_q  <= DONE;
            done_q   <= 1'b1;
            result_q <= res_d;
            rreg_q   <= dest_q;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy            = (state_q != IDLE);
  assign done            = done_q;
  assign result          = result_q;
  assign result_register = rreg_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit unsigned multiply/divide unit downstream of the register file in the non-pipelined processor. Consumes the two register-file read operands, computes one of MUL / MULHU / DIVU / REMU over multiple cycles, and presents the result together with the destination register number for write-back into the register file. A busy/done handshake lets the control unit stall while the operation runs.

## Interface
- DATA_WIDTH, 32, operand and result width
- REG_ADDR_WIDTH, 5, register-file address width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder)
- operand_a  input  DATA_WIDTH  multiplicand / dividend (register-file read_data1)
- operand_b  input  DATA_WIDTH  multiplier / divisor (register-file read_data2)
- dest_register  input  REG_ADDR_WIDTH  write-back target, captured with start
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse: result valid, drives register-file write_enable
- result  output  DATA_WIDTH  write_data to register file; held until next accepted start
- result_register  output  REG_ADDR_WIDTH  write_register to register file; held with result

## Operation
- States: IDLE, RUN, DONE. Reset (any time, including mid-operation) forces IDLE, busy=0, done=0, result=0, result_register=0, counter=0; in-flight operation discarded, no write-back.
- IDLE: start=1 captures op, operand_a, operand_b, dest_register; go RUN, counter=0. start=0: stay.
- RUN: one bit per cycle. Multiply: shift-add over 64-bit accumulator, LSB of multiplier first. Divide: restoring division, MSB of dividend first, 33-bit partial remainder. counter increments each RUN cycle; on the cycle counter==DATA_WIDTH-1 the final bit is processed and state goes DONE.
- DONE: done=1 for exactly one cycle, result/result_register valid; next edge go IDLE unconditionally.
- Divide by zero (op 10/11, operand_b==0): IDLE goes straight to DONE, skipping RUN. DIVU result=all ones (0xFFFFFFFF); REMU result=operand_a. Multiply by zero takes the normal full latency.
- start while busy (RUN or DONE) ignored; no queueing, operand inputs may change freely.
- Operand inputs only sampled on accepted start; later changes have no effect.
- All arithmetic unsigned, modulo 2^DATA_WIDTH per output half; MUL returns product[31:0], MULHU product[63:32].

## Timing
- Accepting edge E0: start=1 in IDLE. busy=1 from after E0.
- Normal ops: RUN for edges E1..E32; DONE entered at E32; done=1 between E32 and E33; IDLE at E33, busy=0 after E33. Latency start-to-done = 32 cycles.
- Divide by zero: DONE entered at E0; done=1 between E0 and E1; IDLE after E1.
- result and result_register update at the edge entering DONE and are stable until the edge entering DONE of the next operation.
- Earliest back-to-back start: sampled at E33 (first IDLE cycle); one-cycle IDLE gap is mandatory.
- No combinational path from any input to any output.

## Test plan
- MUL, a=0x12345678, b=0x00000003, dest=5 -> done exactly 32 cycles after start, result=0x369D0368, result_register=5, done width 1 cycle.
- MULHU, a=b=0xFFFFFFFF, dest=7 -> result=0xFFFFFFFE after 32 cycles; rerun as MUL -> result=0x00000001.
- DIVU a=100, b=7 -> result=0x0000000E; REMU same operands -> result=0x00000002; both 32-cycle latency.
- DIVU a=0x12345678, b=0 -> done one cycle after start, result=0xFFFFFFFF; REMU same -> result=0x12345678.
- start pulsed with new operands at cycles 5 and 31 of a running MUL -> ignored; original result delivered, single done pulse, busy never drops early.
- reset asserted asynchronously mid-RUN (cycle 10) -> busy, done, result, result_register read 0 immediately; no done pulse; next start completes normally.
